piso_axis_packer: RTL and testbench

- Downstream neighbour of the PE-array PISO serializer. Consumes its serial stream of complex samples (valid + 2*DATA_WIDTH data, no backpressure available) and groups every PE_NUM consecutive samples into one frame.
- Frames are buffered in a small FIFO and presented on an AXI4-Stream master with TLAST on the final sample of each frame.
- Produces a frame-space indication so the load controller issues the next PISO load only when a whole frame fits; detects and flags overflow.

---
 rtl/piso_axis_packer_pkg.sv | 11 +
 rtl/piso_axis_packer_if.sv | 14 +
 rtl/piso_axis_packer_sync_fifo_fwft.sv | 61 ++++++
 rtl/piso_axis_packer.sv | 89 ++++++++
 tb/tb_piso_axis_packer.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/piso_axis_packer_pkg.sv
// Shared constants for the PISO-to-AXIS packer and the load controller that
// gates PISO loads on frame_space.
package piso_axis_packer_pkg;

  localparam int unsigned DATA_WIDTH      = 16;
  localparam int unsigned PE_NUM          = 8;
  localparam int unsigned PACK_FIFO_DEPTH = 16;
  localparam int unsigned FCNT_W          = 16;
  localparam int unsigned SAMPLE_W        = 2 * DATA_WIDTH;

endpackage

// File: rtl/piso_axis_packer_if.sv
// AXI4-Stream bus carrying packed frames out of the packer.
interface piso_axis_packer_if #(
  parameter int unsigned TDATA_W = piso_axis_packer_pkg::SAMPLE_W
) ();

  logic [TDATA_W-1:0] m_tdata;
  logic               m_tvalid;
  logic               m_tready;
  logic               m_tlast;

  modport master (output m_tdata, output m_tvalid, output m_tlast, input m_tready);
  modport slave  (input m_tdata, input m_tvalid, input m_tlast, output m_tready);

endinterface

// File: rtl/piso_axis_packer_sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO; full/empty decode from the
// registered count so a same-cycle pop never admits a write.
module sync_fifo_fwft
  import piso_axis_packer_pkg::*;
#(
  parameter int unsigned WIDTH = SAMPLE_W + 1,
  parameter int unsigned DEPTH = PACK_FIFO_DEPTH,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             wr_en, rd_en;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign wr_en   = push_i && !full_o;
  assign rd_en   = pop_i && !empty_o;

  // Head is forced to zero when empty so an idle bus shows all-zero data.
  assign dout_o  = empty_o ? '0 : mem_q[rptr_q];

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q + CW'(wr_en) - CW'(rd_en);
    if (wr_en) wptr_d = wptr_q + 1'b1;
    if (rd_en) rptr_d = rptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q] <= din_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/piso_axis_packer.sv
// Groups the PISO serial sample stream into PE_NUM-sample frames, buffers
// them and presents them as AXI4-Stream with TLAST, frame-space and overflow.
module piso_axis_packer #(
  parameter int unsigned DATA_WIDTH = piso_axis_packer_pkg::DATA_WIDTH,
  parameter int unsigned PE_NUM     = piso_axis_packer_pkg::PE_NUM,
  parameter int unsigned FIFO_DEPTH = piso_axis_packer_pkg::PACK_FIFO_DEPTH,
  parameter int unsigned FCNT_W     = piso_axis_packer_pkg::FCNT_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_in_v,
  input  logic [2*DATA_WIDTH-1:0] s_in,
  piso_axis_packer_if.master      m_axis,
  output logic                    frame_space,
  output logic                    ovf,
  input  logic                    ovf_clr,
  output logic [FCNT_W-1:0]       frames_out
);

  import piso_axis_packer_pkg::*;

  localparam int unsigned SW = 2 * DATA_WIDTH;
  localparam int unsigned IW = $clog2(PE_NUM);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [IW-1:0]     idx_q, idx_d;
  logic              ovf_q, ovf_d;
  logic [FCNT_W-1:0] frames_q, frames_d;

  logic              idx_last;
  logic              fifo_full, fifo_empty, fifo_push, fifo_pop, drop;
  logic [CW-1:0]     fifo_count;
  logic [SW:0]       fifo_head;
  logic              head_last;
  logic [SW-1:0]     head_data;

  assign idx_last  = (idx_q == IW'(PE_NUM - 1));
  assign fifo_push = s_in_v && !fifo_full;
  assign drop      = s_in_v && fifo_full;
  assign fifo_pop  = !fifo_empty && m_axis.m_tready;
  assign {head_last, head_data} = fifo_head;

  sync_fifo_fwft #(
    .WIDTH (SW + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .din_i   ({idx_last, s_in}),
    .dout_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign m_axis.m_tvalid = !fifo_empty;
  assign m_axis.m_tdata  = head_data;
  assign m_axis.m_tlast  = head_last;
  assign frame_space     = (DEPTH_C - fifo_count) >= CW'(PE_NUM);
  assign ovf             = ovf_q;
  assign frames_out      = frames_q;

  // idx advances on every valid sample, stored or dropped, to keep alignment.
  always_comb begin
    idx_d    = idx_q;
    ovf_d    = ovf_q;
    frames_d = frames_q;
    if (s_in_v) idx_d = idx_last ? '0 : idx_q + 1'b1;
    if (drop)         ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
    if (fifo_pop && head_last) frames_d = frames_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q    <= '0;
      ovf_q    <= 1'b0;
      frames_q <= '0;
    end else begin
      idx_q    <= idx_d;
      ovf_q    <= ovf_d;
      frames_q <= frames_d;
    end
  end

endmodule

// File: tb/tb_piso_axis_packer.sv
// Directed, table-driven bench for piso_axis_packer (DATA_WIDTH=16, PE_NUM=8, depth 16).
module tb_piso_axis_packer;

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        r;
    logic        c;
    logic        ev;
    logic [31:0] ed;
    logic        el;
    logic        efs;
    logic        eovf;
    logic [15:0] efr;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_in_v;
  logic [31:0] s_in;
  logic        frame_space, ovf, ovf_clr;
  logic [15:0] frames_out;

  int unsigned tests = 0;
  int unsigned fails = 0;
  vec_t        tbl[$];

  piso_axis_packer_if #(.TDATA_W(32)) axis ();

  piso_axis_packer #(
    .DATA_WIDTH (16),
    .PE_NUM     (8),
    .FIFO_DEPTH (16),
    .FCNT_W     (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_in_v      (s_in_v),
    .s_in        (s_in),
    .m_axis      (axis.master),
    .frame_space (frame_space),
    .ovf         (ovf),
    .ovf_clr     (ovf_clr),
    .frames_out  (frames_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic ev, input logic [31:0] ed, input logic el,
                       input logic efs, input logic eovf, input logic [15:0] efr);
    tests++;
    if (axis.m_tvalid !== ev || axis.m_tdata !== ed || axis.m_tlast !== el ||
        frame_space !== efs || ovf !== eovf || frames_out !== efr) begin
      fails++;
      $display("FAIL %s: got v=%0b d=%h l=%0b fs=%0b ovf=%0b fr=%0d, want v=%0b d=%h l=%0b fs=%0b ovf=%0b fr=%0d",
               name, axis.m_tvalid, axis.m_tdata, axis.m_tlast, frame_space, ovf, frames_out,
               ev, ed, el, efs, eovf, efr);
    end
  endtask

  function automatic void add(input logic v, input logic [31:0] d, input logic r, input logic c,
                              input logic ev, input logic [31:0] ed, input logic el,
                              input logic efs, input logic eovf, input logic [15:0] efr);
    vec_t t;
    t.v = v; t.d = d; t.r = r; t.c = c;
    t.ev = ev; t.ed = ed; t.el = el; t.efs = efs; t.eovf = eovf; t.efr = efr;
    tbl.push_back(t);
  endfunction

  // Apply one vector for a cycle, then check the state after the edge.
  task automatic step(input vec_t t, input string name);
    s_in_v = t.v; s_in = t.d; axis.m_tready = t.r; ovf_clr = t.c;
    @(posedge clk);
    #1;
    check(name, t.ev, t.ed, t.el, t.efs, t.eovf, t.efr);
  endtask

  task automatic run_table(input string name);
    foreach (tbl[i]) step(tbl[i], $sformatf("%s[%0d]", name, i));
    tbl.delete();
  endtask

  // Frame streamed with m_tready=1: each sample appears one cycle after entry.
  function automatic void add_stream_frame(input logic [31:0] base, input logic [15:0] fr);
    for (int k = 0; k < 8; k++)
      add(1'b1, base + 32'(k), 1'b1, 1'b0, 1'b1, base + 32'(k), k == 7, 1'b1, 1'b0, fr);
    add(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, fr + 16'd1);
  endfunction

  // 16 samples into a stalled FIFO; head stays on the first one.
  function automatic void add_fill(input logic [31:0] base, input logic [15:0] fr);
    for (int i = 0; i < 16; i++)
      add(1'b1, base + 32'(i), 1'b0, 1'b0, 1'b1, base, 1'b0, (i + 1) <= 8, 1'b0, fr);
  endfunction

  // Drain a full FIFO with m_tready=1 every cycle.
  function automatic void add_drain(input logic [31:0] base, input logic [15:0] fr);
    for (int i = 0; i < 16; i++)
      add(1'b0, 32'h0, 1'b1, 1'b0, i < 15, (i < 15) ? base + 32'(i + 1) : 32'h0,
          (i < 15) && ((i + 1) % 8 == 7), i >= 7, 1'b0,
          fr + 16'(i >= 7) + 16'(i >= 15));
  endfunction

  initial begin
    vec_t t;
    rst_n = 1'b0; s_in_v = 1'b0; s_in = '0; axis.m_tready = 1'b0; ovf_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_held", 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 16'd0);
    rst_n = 1'b1;
    add(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 16'd0);
    add(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 16'd0);
    run_table("idle");

    add_stream_frame(32'h0000_0001, 16'd0);
    run_table("single_frame");

    add_fill(32'h0000_0011, 16'd1);
    run_table("bp_fill");
    // Alternate stall/accept: data must hold during the stall cycle.
    for (int i = 0; i < 16; i++) begin
      add(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h11 + 32'(i), (i % 8) == 7, i >= 8, 1'b0,
          16'd1 + 16'(i >= 8));
      add(1'b0, 32'h0, 1'b1, 1'b0, i < 15, (i < 15) ? 32'h12 + 32'(i) : 32'h0,
          (i < 15) && ((i + 1) % 8 == 7), i >= 7, 1'b0,
          16'd1 + 16'(i >= 7) + 16'(i >= 15));
    end
    run_table("bp_drain");

    add_fill(32'h0000_0031, 16'd3);
    run_table("ovf_fill");
    for (int i = 0; i < 8; i++) begin
      t = '{v: 1'b1, d: 32'h41 + 32'(i), r: 1'b0, c: 1'b0,
            ev: 1'b1, ed: 32'h31, el: 1'b0, efs: 1'b0, eovf: 1'b1, efr: 16'd3};
      step(t, $sformatf("ovf_drop[%0d]", i));
    end
    t = '{v: 1'b0, d: 32'h0, r: 1'b0, c: 1'b1,
          ev: 1'b1, ed: 32'h31, el: 1'b0, efs: 1'b0, eovf: 1'b0, efr: 16'd3};
    step(t, "ovf_clr");
    add_drain(32'h0000_0031, 16'd3);
    run_table("ovf_drain");
    add_stream_frame(32'h0000_0071, 16'd5);
    run_table("ovf_align");

    add_fill(32'h0000_0051, 16'd6);
    run_table("sim_fill");
    t = '{v: 1'b1, d: 32'h61, r: 1'b1, c: 1'b0,
          ev: 1'b1, ed: 32'h52, el: 1'b0, efs: 1'b0, eovf: 1'b1, efr: 16'd6};
    step(t, "sim_push_pop_full");
    t = '{v: 1'b1, d: 32'h62, r: 1'b0, c: 1'b1,
          ev: 1'b1, ed: 32'h52, el: 1'b0, efs: 1'b0, eovf: 1'b0, efr: 16'd6};
    step(t, "sim_count15_write");
    t = '{v: 1'b1, d: 32'h63, r: 1'b0, c: 1'b1,
          ev: 1'b1, ed: 32'h52, el: 1'b0, efs: 1'b0, eovf: 1'b1, efr: 16'd6};
    step(t, "sim_set_beats_clr");

    for (int i = 0; i < 3; i++) begin
      t = '{v: 1'b1, d: 32'h91 + 32'(i), r: 1'b0, c: 1'b0,
            ev: 1'b1, ed: 32'h52, el: 1'b0, efs: 1'b0, eovf: 1'b1, efr: 16'd6};
      step(t, $sformatf("midframe[%0d]", i));
    end
    s_in_v = 1'b0; axis.m_tready = 1'b0;
    rst_n = 1'b0;
    #1;
    check("async_reset", 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 16'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    add_stream_frame(32'h0000_0081, 16'd0);
    run_table("post_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
